sram_port_arbiter: RTL and testbench

Controller that shares one single-port RW SRAM macro (8192 x 5, synchronous read, one-cycle read latency) between an independent write requester and read requester. It sits between the pipeline stages that own the table and the generated `*_ext` array wrapper. It performs a full-array zero-clear after reset or on request, then round-robin arbitrates the single RW port. The read response is returned with fixed one-cycle latency.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_port_arbiter_if.sv | 27 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/sram_port_arbiter.sv | 100 ++++++++++
 tb/tb_sram_port_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and default geometry for SRAM port sharing controllers
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 5;
  localparam int DEF_DEPTH  = 8192;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } arb_state_e;

  typedef enum logic {
    PTR_READ,
    PTR_WRITE
  } rr_ptr_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - write/read requester and read response bundle
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 5
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with grant enable and registered pointer
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic req_rd,
  input  logic req_wr,
  output logic gnt_rd,
  output logic gnt_wr
);

  rr_ptr_e ptr_q;

  // Pointer only matters under contention; a lone requester always wins.
  always_comb begin
    gnt_rd = en && req_rd && (!req_wr || (ptr_q == PTR_READ));
    gnt_wr = en && req_wr && (!req_rd || (ptr_q == PTR_WRITE));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= PTR_READ;
    end else if (gnt_rd) begin
      ptr_q <= PTR_WRITE;
    end else if (gnt_wr) begin
      ptr_q <= PTR_READ;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - zero-clear sequencer and round-robin sharer of one RW SRAM port
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear_req,
  output logic                init_done,
  sram_port_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_active;
  logic              gnt_rd, gnt_wr;
  logic              resp_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      resp_valid_q <= gnt_rd;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state_q == ST_RUN),
    .req_rd  (bus.rd_valid),
    .req_wr  (bus.wr_valid),
    .gnt_rd  (gnt_rd),
    .gnt_wr  (gnt_wr)
  );

  // Reset parks in CLEAR; gating with reset_n keeps the macro idle while reset is held.
  assign clr_active = (state_q == ST_CLEAR) && reset_n;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (clr_active) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = clr_cnt_q;
    end else if (gnt_wr) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = bus.wr_addr;
      sram_wdata = bus.wr_data;
    end else if (gnt_rd) begin
      sram_en    = 1'b1;
      sram_addr  = bus.rd_addr;
    end
  end

  assign init_done         = (state_q == ST_RUN);
  assign bus.wr_ready      = gnt_wr;
  assign bus.rd_ready      = gnt_rd;
  assign bus.rd_resp_valid = resp_valid_q;
  assign bus.rd_resp_data  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized bench for sram_port_arbiter against a behavioural model
module tb_sram_port_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 5;
  localparam int DEPTH  = 8192;

  logic              clock;
  logic              reset_n;
  logic              clear_req;
  logic              init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .init_done  (init_done),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro stand-in: single port, synchronous read, one-cycle latency.
  logic [DATA_W-1:0] tb_mem [0:DEPTH-1];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) tb_mem[sram_addr] <= sram_wdata;
      else            sram_rdata <= tb_mem[sram_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: phase, clear position, contention preference, memory image.
  bit m_run;
  int m_clr;
  bit m_pref_wr;
  bit m_pend;
  int m_pend_data;
  int m_mem [DEPTH];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run     = 1'b0;
    m_clr     = 0;
    m_pref_wr = 1'b0;
    m_pend    = 1'b0;
  endtask

  // Called at posedge+1; drives one cycle, checks at negedge, advances model, returns at posedge+1.
  task automatic cycle(input bit wv, input int wa, input int wd,
                       input bit rv, input int ra, input bit clr);
    bit exp_wg, exp_rg, exp_en, exp_wm;
    int exp_addr, exp_wdata, next_data;
    bus.wr_valid = wv;
    bus.wr_addr  = ADDR_W'(wa);
    bus.wr_data  = DATA_W'(wd);
    bus.rd_valid = rv;
    bus.rd_addr  = ADDR_W'(ra);
    clear_req    = clr;
    @(negedge clock);
    exp_wg = 0; exp_rg = 0; exp_en = 0; exp_wm = 0; exp_addr = 0; exp_wdata = 0;
    if (!m_run) begin
      exp_en = 1; exp_wm = 1; exp_addr = m_clr;
    end else begin
      if (wv && rv) begin
        exp_wg = m_pref_wr;
        exp_rg = !m_pref_wr;
      end else begin
        exp_wg = wv;
        exp_rg = rv;
      end
      if (exp_wg) begin
        exp_en = 1; exp_wm = 1; exp_addr = wa; exp_wdata = wd;
      end else if (exp_rg) begin
        exp_en = 1; exp_addr = ra;
      end
    end
    check_eq("init_done", int'(init_done), int'(m_run));
    check_eq("wr_ready", int'(bus.wr_ready), int'(exp_wg));
    check_eq("rd_ready", int'(bus.rd_ready), int'(exp_rg));
    check_eq("sram_en", int'(sram_en), int'(exp_en));
    check_eq("sram_wmode", int'(sram_wmode), int'(exp_wm));
    check_eq("sram_addr", int'(sram_addr), exp_addr);
    check_eq("sram_wdata", int'(sram_wdata), exp_wdata);
    check_eq("rd_resp_valid", int'(bus.rd_resp_valid), int'(m_pend));
    if (m_pend) check_eq("rd_resp_data", int'(bus.rd_resp_data), m_pend_data);
    next_data = exp_rg ? m_mem[ra] : 0;
    if (exp_wg) m_mem[wa] = wd;
    if (exp_rg) m_pref_wr = 1'b1;
    else if (exp_wg) m_pref_wr = 1'b0;
    if (!m_run) begin
      m_mem[m_clr] = 0;
      if (m_clr == DEPTH - 1) begin
        m_run = 1'b1;
        m_clr = 0;
      end else begin
        m_clr++;
      end
    end else if (clr) begin
      m_run = 1'b0;
      m_clr = 0;
    end
    m_pend      = exp_rg;
    m_pend_data = next_data;
    @(posedge clock);
    #1;
  endtask

  task automatic rand_cycle(input int amax);
    cycle($urandom_range(0, 1), $urandom_range(0, amax), $urandom_range(0, 31),
          $urandom_range(0, 1), $urandom_range(0, amax), 1'b0);
  endtask

  // Asserts reset mid-cycle and checks that outputs fall without waiting for a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_init_done", int'(init_done), 0);
    check_eq("rst_wr_ready", int'(bus.wr_ready), 0);
    check_eq("rst_rd_ready", int'(bus.rd_ready), 0);
    check_eq("rst_resp_valid", int'(bus.rd_resp_valid), 0);
    check_eq("rst_sram_en", int'(sram_en), 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    clear_req    = 1'b0;
    bus.wr_valid = 1'b1;
    bus.rd_valid = 1'b1;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = '0;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // Initial clear with requesters pushing: nothing may be accepted.
    repeat (DEPTH) rand_cycle(DEPTH - 1);

    // Contention from the reset-state pointer: R, W, R, W, R, W.
    for (int i = 0; i < 6; i++) begin
      cycle(1, 40 + i, i + 1, 1, 40 + i, 0);
    end

    cycle(1, 5, 'h1A, 0, 0, 0);
    cycle(0, 0, 0, 1, 5, 0);
    cycle(0, 0, 0, 1, 8000, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Back-to-back streaming from one requester.
    for (int i = 0; i < 16; i++) cycle(1, 200 + i, (i * 7 + 3) % 32, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 200 + i, 0);
    cycle(0, 0, 0, 0, 0, 0);

    repeat (400) rand_cycle(15);

    // clear_req coinciding with a read grant: response lands in the first clear cycle.
    cycle(1, 100, 'h1F, 0, 0, 0);
    cycle(0, 0, 0, 1, 100, 1);
    repeat (DEPTH) rand_cycle(DEPTH - 1);
    cycle(0, 0, 0, 1, 100, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset while a response is in flight.
    cycle(1, 7, 9, 0, 0, 0);
    cycle(0, 0, 0, 1, 7, 0);
    do_reset();

    // Reset partway through the clear sweep.
    for (int i = 0; i < DEPTH && m_clr != 3000; i++) rand_cycle(DEPTH - 1);
    check_eq("clr_reached_3000", m_clr, 3000);
    do_reset();
    repeat (DEPTH) rand_cycle(DEPTH - 1);
    repeat (100) rand_cycle(31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
